issue_queue_ooo: RTL and testbench

Parametrised out-of-order issue queue; successor to the single in-order issue stage between decode/rename and execute. Holds up to IQ_DEPTH renamed instructions, wakes up source operands from WB_PORTS writeback tag broadcasts, and issues the oldest ready entry each cycle. Collapsing organisation: entry 0 is always the oldest valid entry.

---
 rtl/issue_queue_ooo_if.sv | 41 ++++
 rtl/issue_queue_ooo.sv | 113 +++++++++++
 tb/tb_issue_queue_ooo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_ooo_if.sv
// Dispatch / wakeup / issue bundle for issue_queue_ooo.
//   master: the pipeline side (decode/rename dispatch, writeback broadcasts, execute accept)
//   slave : the issue queue
// Signals:
//   in_valid/in_ready, in_rob_id, in_src{1,2}_rdy/_tag, in_payload : dispatch handshake
//   wb_valid[WB_PORTS], wb_tag[WB_PORTS*ROB]                         : wakeup broadcasts
//   out_valid/out_ready, out_rob_id, out_payload                    : issue handshake
interface issue_queue_ooo_if #(
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned PAYLOAD   = 64
);
  localparam int unsigned RobW = $clog2(ROB_DEPTH);

  logic                     in_valid;
  logic                     in_ready;
  logic [RobW-1:0]          in_rob_id;
  logic                     in_src1_rdy;
  logic [RobW-1:0]          in_src1_tag;
  logic                     in_src2_rdy;
  logic [RobW-1:0]          in_src2_tag;
  logic [PAYLOAD-1:0]       in_payload;
  logic [WB_PORTS-1:0]      wb_valid;
  logic [WB_PORTS*RobW-1:0] wb_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [RobW-1:0]          out_rob_id;
  logic [PAYLOAD-1:0]       out_payload;

  modport master (
    output in_valid, in_rob_id, in_src1_rdy, in_src1_tag, in_src2_rdy, in_src2_tag, in_payload,
    output wb_valid, wb_tag, out_ready,
    input  in_ready, out_valid, out_rob_id, out_payload
  );

  modport slave (
    input  in_valid, in_rob_id, in_src1_rdy, in_src1_tag, in_src2_rdy, in_src2_tag, in_payload,
    input  wb_valid, wb_tag, out_ready,
    output in_ready, out_valid, out_rob_id, out_payload
  );
endinterface

// File: rtl/issue_queue_ooo.sv
// Collapsing out-of-order issue queue. Entry 0 is always the oldest; occupied entries are
// exactly indices 0..count-1. Source operands wake up from writeback tag broadcasts and the
// oldest fully-ready entry is issued each cycle.
// Ports:
//   clk, reset_ (async, active low), flush (sync, clears the queue)
//   count : occupied entries
//   bus   : dispatch / wakeup / issue bundle (slave side)
module issue_queue_ooo #(
  parameter int unsigned IQ_DEPTH  = 8,
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned PAYLOAD   = 64
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          flush,
  output logic [$clog2(IQ_DEPTH+1)-1:0] count,
  issue_queue_ooo_if.slave              bus
);
  localparam int unsigned RobW = $clog2(ROB_DEPTH);
  localparam int unsigned CntW = $clog2(IQ_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic [RobW-1:0]    rob_id;
    logic               src1_rdy;
    logic [RobW-1:0]    src1_tag;
    logic               src2_rdy;
    logic [RobW-1:0]    src2_tag;
    logic [PAYLOAD-1:0] payload;
  } entry_t;

  entry_t          ent_q [IQ_DEPTH];
  entry_t          ent_d [IQ_DEPTH];
  entry_t          woke  [IQ_DEPTH];
  entry_t          new_ent;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] wr_idx;
  logic [IQ_DEPTH-1:0] ready;
  logic [IdxW-1:0] sel;
  logic            any_rdy, dispatch, issue;

  function automatic logic tag_hit(input logic [WB_PORTS-1:0]      v,
                                   input logic [WB_PORTS*RobW-1:0] tags,
                                   input logic [RobW-1:0]          tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < int'(WB_PORTS); p++) begin
      if (v[p] && (tags[p*RobW +: RobW] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Select: lowest-index (oldest) entry with both sources ready.
  always_comb begin
    ready = '0;
    sel   = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      ready[i] = (CntW'(i) < count_q) && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
    end
    for (int i = int'(IQ_DEPTH) - 1; i >= 0; i--) begin
      if (ready[i]) sel = IdxW'(i);
    end
    any_rdy = |ready;
  end

  assign bus.out_valid   = any_rdy && !flush;
  assign bus.in_ready    = (count_q < CntW'(IQ_DEPTH)) && !flush;
  assign bus.out_rob_id  = ent_q[sel].rob_id;
  assign bus.out_payload = ent_q[sel].payload;
  assign count           = count_q;

  assign dispatch = bus.in_valid && bus.in_ready;
  assign issue    = bus.out_valid && bus.out_ready;
  // With a same-cycle issue the collapse frees a slot, so the new entry lands one lower.
  assign wr_idx   = count_q - CntW'(issue);

  always_comb begin
    count_d = flush ? '0 : (count_q + CntW'(dispatch) - CntW'(issue));

    // Wakeup applied before the collapse so shifted entries keep this cycle's broadcasts.
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      woke[i]          = ent_q[i];
      woke[i].src1_rdy = ent_q[i].src1_rdy | tag_hit(bus.wb_valid, bus.wb_tag, ent_q[i].src1_tag);
      woke[i].src2_rdy = ent_q[i].src2_rdy | tag_hit(bus.wb_valid, bus.wb_tag, ent_q[i].src2_tag);
    end

    new_ent.rob_id   = bus.in_rob_id;
    new_ent.src1_rdy = bus.in_src1_rdy | tag_hit(bus.wb_valid, bus.wb_tag, bus.in_src1_tag);
    new_ent.src1_tag = bus.in_src1_tag;
    new_ent.src2_rdy = bus.in_src2_rdy | tag_hit(bus.wb_valid, bus.wb_tag, bus.in_src2_tag);
    new_ent.src2_tag = bus.in_src2_tag;
    new_ent.payload  = bus.in_payload;

    for (int i = 0; i < int'(IQ_DEPTH); i++) ent_d[i] = woke[i];
    for (int i = 0; i < int'(IQ_DEPTH) - 1; i++) begin
      if (issue && (IdxW'(i) >= sel)) ent_d[i] = woke[i+1];
    end
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      if (dispatch && (CntW'(i) == wr_idx)) ent_d[i] = new_ent;
    end
  end

  // Occupancy is the only state needing reset: entries at or above count are ignored.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) count_q <= '0;
    else         count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(IQ_DEPTH); i++) ent_q[i] <= ent_d[i];
  end
endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed, table-driven bench for issue_queue_ooo. Each vector is one clock cycle: inputs
// are driven on the falling edge, outputs compared 1 ns later, state advances on the rise.
module tb_issue_queue_ooo;
  localparam int unsigned IQ_DEPTH  = 8;
  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned WB_PORTS  = 2;
  localparam int unsigned PAYLOAD   = 64;

  typedef struct {
    logic       iv;
    logic [4:0] rob;
    logic       s1r;
    logic [4:0] s1t;
    logic       s2r;
    logic [4:0] s2t;
    logic [1:0] wbv;
    logic [4:0] wbt0;
    logic [4:0] wbt1;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [4:0] e_rob;
    logic [3:0] e_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_;
  logic       flush;
  logic [3:0] count;
  int         n_cmp = 0;
  int         n_err = 0;
  vec_t       vecs[$];

  issue_queue_ooo_if #(.ROB_DEPTH(ROB_DEPTH), .WB_PORTS(WB_PORTS), .PAYLOAD(PAYLOAD)) bus ();

  issue_queue_ooo #(
    .IQ_DEPTH (IQ_DEPTH),
    .ROB_DEPTH(ROB_DEPTH),
    .WB_PORTS (WB_PORTS),
    .PAYLOAD  (PAYLOAD)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pay(input logic [4:0] r);
    return 64'h5A5A_0000_0000_0000 | {54'h0, ~r, r};
  endfunction

  function automatic vec_t mk(input int iv, input int rob, input int s1r, input int s1t,
                              input int s2r, input int s2t, input int wbv, input int wbt0,
                              input int wbt1, input int ordy, input int fl, input int eir,
                              input int eov, input int erob, input int ecnt);
    vec_t v;
    v.iv = 1'(iv);     v.rob = 5'(rob);   v.s1r = 1'(s1r);   v.s1t = 5'(s1t);
    v.s2r = 1'(s2r);   v.s2t = 5'(s2t);   v.wbv = 2'(wbv);   v.wbt0 = 5'(wbt0);
    v.wbt1 = 5'(wbt1); v.ordy = 1'(ordy); v.fl = 1'(fl);     v.e_ir = 1'(eir);
    v.e_ov = 1'(eov);  v.e_rob = 5'(erob); v.e_cnt = 4'(ecnt);
    return v;
  endfunction

  // Idle cycle: no dispatch, no flush, optional wakeups.
  function automatic vec_t idl(input int wbv, input int wbt0, input int wbt1, input int ordy,
                               input int eir, input int eov, input int erob, input int ecnt);
    return mk(0, 0, 0, 0, 0, 0, wbv, wbt0, wbt1, ordy, 0, eir, eov, erob, ecnt);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid    = v.iv;
    bus.in_rob_id   = v.rob;
    bus.in_src1_rdy = v.s1r;
    bus.in_src1_tag = v.s1t;
    bus.in_src2_rdy = v.s2r;
    bus.in_src2_tag = v.s2t;
    bus.in_payload  = pay(v.rob);
    bus.wb_valid    = v.wbv;
    bus.wb_tag      = {v.wbt1, v.wbt0};
    bus.out_ready   = v.ordy;
    flush           = v.fl;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(v.e_ir));
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(v.e_ov));
    chk({tag, " count"}, 64'(count), 64'(v.e_cnt));
    if (v.e_ov) begin
      chk({tag, " out_rob_id"}, 64'(bus.out_rob_id), 64'(v.e_rob));
      chk({tag, " out_payload"}, bus.out_payload, pay(v.e_rob));
    end
  endtask

  initial begin
    reset_ = 1'b0;
    drive(idl(0, 0, 0, 0, 1, 0, 0, 0));
    repeat (3) @(negedge clk);
    reset_ = 1'b1;

    // Reset state
    vecs.push_back(idl(0, 0, 0, 0, 1, 0, 0, 0));
    // Single ready dispatch, issue, drain
    vecs.push_back(mk(1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 3, 1));
    vecs.push_back(idl(0, 0, 0, 0, 1, 0, 0, 0));
    // Younger ready entry bypasses older waiting one; wakeup one cycle before issue
    vecs.push_back(mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(idl(2'b00, 0, 5, 1, 1, 1, 2, 2));   // matching tag but wb_valid low
    vecs.push_back(idl(2'b10, 0, 5, 1, 1, 0, 0, 1));   // broadcast: not yet selectable
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(idl(0, 0, 0, 0, 1, 0, 0, 0));
    // Wakeup in the dispatch cycle
    vecs.push_back(mk(1, 7, 1, 0, 0, 9, 2'b01, 9, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 7, 1));
    vecs.push_back(idl(0, 0, 0, 0, 1, 0, 0, 0));
    // Fill with never-ready entries rob 10..17 (src1 tag 20..27)
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1, 10 + k, 0, 20 + k, 1, 0, 0, 0, 0, 1, 0,
                                                  1, 0, 0, k));
    vecs.push_back(mk(1, 18, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8));   // refused when full
    vecs.push_back(idl(2'b01, 24, 0, 1, 0, 0, 0, 8));  // wake entry 4 (rob 14)
    vecs.push_back(idl(0, 0, 0, 1, 0, 1, 14, 8));
    vecs.push_back(idl(0, 0, 0, 0, 1, 0, 0, 7));
    // Age order of survivors [10,11,12,13,15,16,17]
    vecs.push_back(idl(2'b11, 27, 25, 1, 1, 0, 0, 7));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 15, 7));
    vecs.push_back(idl(2'b11, 26, 20, 1, 1, 1, 17, 6));
    vecs.push_back(idl(2'b11, 22, 23, 1, 1, 1, 10, 5));
    vecs.push_back(idl(0, 0, 0, 0, 1, 1, 12, 4));
    vecs.push_back(idl(2'b01, 21, 0, 0, 1, 1, 12, 4));
    // Issue + dispatch together at count 4: rob 20 becomes the youngest
    vecs.push_back(mk(1, 20, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 11, 4));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 12, 4));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 13, 3));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 16, 2));
    vecs.push_back(idl(0, 0, 0, 1, 1, 1, 20, 1));
    vecs.push_back(idl(0, 0, 0, 0, 1, 0, 0, 0));
    // Flush at count 5 with ready entries and a dispatch request
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 1 + k, 1, 0, 1, 0, 0, 0, 0, 0, 0,
                                                  1, (k > 0) ? 1 : 0, 1, k));
    vecs.push_back(mk(1, 6, 1, 0, 1, 0, 2'b01, 3, 0, 1, 1, 0, 0, 0, 5));
    vecs.push_back(idl(0, 0, 0, 1, 1, 0, 0, 0));

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset in the middle of a cycle
    apply("rst_a", mk(1, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    apply("rst_b", mk(1, 9, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 8, 1));
    apply("rst_c", idl(0, 0, 0, 0, 1, 1, 8, 2));
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_rst count", 64'(count), 64'd0);
    chk("async_rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset_ = 1'b1;
    apply("post_a", idl(0, 0, 0, 0, 1, 0, 0, 0));
    apply("post_b", mk(1, 30, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    apply("post_c", idl(0, 0, 0, 1, 1, 1, 30, 1));
    apply("post_d", idl(0, 0, 0, 0, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
